multdiv_ctrl: RTL

Sequencer between the processor pipeline and the iterative mult and div units.
- Accepts one multiply/divide op and latches operands and destination register.
- Restarts the selected unit, waits for its ready, and holds result plus exception until writeback acknowledges.
- Drives pipeline stall while an op is outstanding; handles flush, divide-by-zero short-circuit and a watchdog timeout.

---
 rtl/multdiv_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencer between the pipeline and the iterative mult/div units.
// Latches one op, restarts the selected unit, holds its result for writeback.
module multdiv_ctrl #(
   parameter int MAX_CYCLES = 40,
   parameter int RD_W       = 5
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic            op,
   input  logic [31:0]     opA,
   input  logic [31:0]     opB,
   input  logic [RD_W-1:0] rd_in,
   input  logic            flush,
   input  logic            res_ack,
   output logic            busy,
   output logic            stall,
   output logic            res_valid,
   output logic [31:0]     result,
   output logic            res_exc,
   output logic [RD_W-1:0] rd_out,
   output logic [31:0]     unit_a,
   output logic [31:0]     unit_b,
   output logic            mul_clr,
   input  logic            mul_ready,
   input  logic [31:0]     mul_result,
   input  logic            mul_exc,
   output logic            div_clr,
   input  logic            div_ready,
   input  logic [31:0]     div_result,
   input  logic            div_exc
);

   localparam int CW = $clog2(MAX_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_op;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [31:0]       r_res;
   logic              r_exc;
   logic              r_valid;
   logic [RD_W-1:0]   r_rd;
   logic [CW-1:0]     r_cnt;
   logic              w_accept;
   logic              w_dz;
   logic              w_rdy;
   logic              w_tmo;
   logic [31:0]       w_ures;
   logic              w_uexc;

   // Selected-unit mux, watchdog limit, div-by-zero and accept decode
   always_comb begin
      w_rdy    = r_op ? div_ready : mul_ready;
      w_ures   = r_op ? div_result : mul_result;
      w_uexc   = r_op ? div_exc : mul_exc;
      w_tmo    = (r_cnt == CW'(MAX_CYCLES - 1));
      w_dz     = op & (opB == 32'd0);
      w_accept = start & ~flush &
                 ((r_state == S_IDLE) |
                  ((r_state == S_DONE) & res_ack));
   end

   // Next-state decode; flush overrides everything
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = w_dz ? S_DONE : S_CLR;
         S_CLR:  w_next = S_RUN;
         S_RUN:  if (w_rdy | w_tmo) w_next = S_DONE;
         S_DONE: begin
            if (res_ack) begin
               if (start) w_next = w_dz ? S_DONE : S_CLR;
               else       w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   // State register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Operand latch, watchdog, result capture and valid flag
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_op    <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_rd    <= '0;
         r_res   <= '0;
         r_exc   <= 1'b0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_op <= op;
            r_a  <= opA;
            r_b  <= opB;
            r_rd <= rd_in;
            if (w_dz) begin
               r_res <= '0;
               r_exc <= 1'b1;
            end
         end
         if ((r_state == S_RUN) && !flush) begin
            if (w_rdy) begin
               r_res <= w_ures;
               r_exc <= w_uexc;
            end else if (w_tmo) begin
               r_res <= '0;
               r_exc <= 1'b1;
            end
         end
         if (r_state == S_CLR)      r_cnt <= '0;
         else if (r_state == S_RUN) r_cnt <= r_cnt + 1'b1;
         r_valid <= (w_next == S_DONE);
      end
   end

   // Combinational status and unit restart decode
   always_comb begin
      busy    = (r_state != S_IDLE);
      stall   = busy & ~((r_state == S_DONE) & res_ack);
      mul_clr = ~clr | ~((r_state == S_RUN) & ~r_op);
      div_clr = ~clr | ~((r_state == S_RUN) & r_op);
   end

   assign res_valid = r_valid;
   assign result    = r_res;
   assign res_exc   = r_exc;
   assign rd_out    = r_rd;
   assign unit_a    = r_a;
   assign unit_b    = r_b;

endmodule
